wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage register file for the 32-bit CPU. It consumes the final writeback mux result, `MUX_OUT`, together with the opcode and destination register of the retiring instruction, and commits it into a 32 x 32-bit register file. It provides two combinational read ports with write-to-read bypass, plus a pending-write scoreboard that flags read-after-write hazards to the issue stage.

## Interface
- `NREG`, 32: number of architectural registers; index width is log2(NREG) = 5.
- `DW`, 32: data width.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `WB_VALID`  in  1  a retiring instruction is present this cycle.
- `WB_OPC`  in  6  opcode of the retiring instruction.
- `WB_RD`  in  5  destination register index.
- `MUX_OUT`  in  32  writeback data from the final mux.
- `ISS_VALID`  in  1  an instruction issues this cycle.
- `ISS_OPC`  in  6  opcode of the issuing instruction.
- `ISS_RD`  in  5  destination register of the issuing instruction.
- `RS1_IDX`, `RS2_IDX`  in  5 each  read port addresses; these are also the issuing instruction's sources.
- `RD1`, `RD2`  out  32 each  read data.
- `HAZARD`  out  1  an issuing source is pending and not satisfied by bypass.
- `PEND_CNT`  out  6  number of registers currently pending (0..31).

## Operation
- Write-enable decode, applied to both WB_OPC and ISS_OPC:
  - Writes a register: ADD(1), SUB(2), LOAD(4), MOVE(5), SGE..NOT(6..15), MOVEI(16), SLI(17), SRI(18), ADDI(19), SUBI(20), ADDF(23), MULF(24).
  - Does not write: NOP(0), STORE(3), JUMP(21), BRA(22), and any opcode 25..63.
- Register 0 is hardwired to zero. A write to index 0 is discarded. Reading index 0 returns 0, with no bypass and no hazard.
- Commit condition: `WB_VALID` is high, WB_OPC decodes as writing, and `WB_RD` != 0. When the condition holds, `regs[WB_RD]` <= `MUX_OUT` at the clock edge.
- Read (combinational), evaluated independently for each port:
  - If the port index is 0, output 0.
  - Else, if a commit is active this cycle and WB_RD equals the port index, output `MUX_OUT` (bypass).
  - Else, output `regs[index]`.
- Scoreboard holds 32 pending bits, one per register:
  - Set: `ISS_VALID`, ISS_OPC decodes as writing, and `ISS_RD` != 0. Sets `pend[ISS_RD]`.
  - Clear: commit active. Clears `pend[WB_RD]`.
  - Set and clear on the same index in the same cycle: set wins, because the newer producer is outstanding.
  - Set on an index that is already pending: the bit stays 1. The count is not incremented twice.
- `HAZARD` = `ISS_VALID` AND (H1 OR H2), where Hn means: RSn_IDX != 0, `pend[RSn_IDX]` is 1, and the bypass does not serve that port this cycle.
- `PEND_CNT` is a registered up/down counter that always equals popcount(pend). Per edge:
  - +1 on a set of a bit that was clear.
  - -1 on a clear of a bit that was set and not re-set in the same cycle.
  - Net 0 when both occur on different indices.
- A commit with no matching pending bit is legal. It writes the register and leaves `PEND_CNT` unchanged.

## Timing
- Write latency: data committed at edge N is visible from `regs` in cycle N+1. In cycle N it is visible only through the bypass.
- Scoreboard: a set at edge N makes `HAZARD` assertable in cycle N+1. There is no same-cycle hazard for an instruction whose source is its own ISS_RD.
- Reset: while `reset` is high at an edge, all regs, all pend bits and `PEND_CNT` clear to 0. Reset wins over a simultaneous commit or set.
  - After reset: `RD1` = `RD2` = 0, `HAZARD` = 0, `PEND_CNT` = 0.
  - Reset mid-operation discards outstanding pending state. No write occurs on the reset edge.
- `RD1`, `RD2` and `HAZARD` are combinational from their inputs. `PEND_CNT` changes only on clock edges.

## Structure
- Shared package `cpu_pkg`:
  - The opcode constants (NOP..MULF, 6-bit), shared with the final writeback mux and the ALU.
  - A function `opc_writes_rd(opc)` implementing the write-enable decode above.
- Sub-module `wb_scoreboard`: owns the pending bits, the set/clear priority, `PEND_CNT` and the `HAZARD` logic.
- The top-level owns the register array and the bypass.

## Test plan
- Reset, then read all indices 1..31 -> `RD1` = `RD2` = 0, `PEND_CNT` = 0.
- Commit ADD, WB_RD=5, `MUX_OUT`=0xDEADBEEF -> same cycle `RD1`(RS1_IDX=5) = 0xDEADBEEF via bypass; next cycle still 0xDEADBEEF via `regs`. Then STORE, WB_RD=5, data 0x1 -> R5 unchanged.
- Commit MOVEI, WB_RD=0, data 0x1234 -> `RD1`(0) = 0 in the commit cycle and in all later cycles.
- Issue ADDI, ISS_RD=7; next cycle issue with RS2_IDX=7 -> `HAZARD`=1, `PEND_CNT`=1. Commit R7 in that same cycle -> `HAZARD`=0 and `RD2`=`MUX_OUT`; `PEND_CNT`=0 after the edge.
- Same cycle: issue ISS_RD=9 and commit WB_RD=9, with R9 already pending -> pend[9] stays 1, `PEND_CNT` unchanged. Issue ISS_RD=3 with commit WB_RD=9 -> count net 0.
- Issue LOAD to R10 and R11, then assert `reset` -> `PEND_CNT`=0 and `HAZARD`=0 next cycle; a commit presented on the reset edge is not written.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: the 6-bit opcode constants used by the ALU, the final
// writeback mux and the register file, plus the write-enable decode that tells
// whether an opcode produces a destination-register result.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int OPC_W = 6;

    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OPC_NOP   = 6'd0;
    localparam opc_t OPC_ADD   = 6'd1;
    localparam opc_t OPC_SUB   = 6'd2;
    localparam opc_t OPC_STORE = 6'd3;
    localparam opc_t OPC_LOAD  = 6'd4;
    localparam opc_t OPC_MOVE  = 6'd5;
    localparam opc_t OPC_SGE   = 6'd6;   // first of the SGE..NOT block
    localparam opc_t OPC_NOT   = 6'd15;  // last of the SGE..NOT block
    localparam opc_t OPC_MOVEI = 6'd16;
    localparam opc_t OPC_SLI   = 6'd17;
    localparam opc_t OPC_SRI   = 6'd18;
    localparam opc_t OPC_ADDI  = 6'd19;
    localparam opc_t OPC_SUBI  = 6'd20;
    localparam opc_t OPC_JUMP  = 6'd21;
    localparam opc_t OPC_BRA   = 6'd22;
    localparam opc_t OPC_ADDF  = 6'd23;
    localparam opc_t OPC_MULF  = 6'd24;

    // True when the opcode writes its destination register. Everything from
    // ADD through SUBI writes except STORE; ADDF and MULF also write. NOP,
    // STORE, JUMP, BRA and the unassigned range 25..63 do not.
    function automatic logic opc_writes_rd(input opc_t opc);
        logic writes;
        writes = 1'b0;
        if ((opc >= OPC_ADD) && (opc <= OPC_SUBI) && (opc != OPC_STORE)) begin
            writes = 1'b1;
        end
        if ((opc == OPC_ADDF) || (opc == OPC_MULF)) begin
            writes = 1'b1;
        end
        return writes;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Pending-write scoreboard for the writeback stage. One pending bit per
// register: set when a writing instruction issues, cleared when its result
// commits. Keeps a registered count of pending bits and flags read-after-write
// hazards for the issuing instruction's two sources.
//
// Ports
//   clock          in   clock, rising edge
//   reset          in   synchronous active-high reset
//   iss_valid_i    in   an instruction issues this cycle
//   iss_writes_i   in   issuing opcode writes its destination
//   iss_rd_i       in   issuing destination index
//   commit_i       in   a register commit is active this cycle (rd != 0)
//   wb_rd_i        in   committing destination index
//   rs1_idx_i      in   issuing source 1 index
//   rs2_idx_i      in   issuing source 2 index
//   hazard_o       out  a source is pending and not served by the bypass
//   pend_cnt_o     out  number of pending registers
// -----------------------------------------------------------------------------
module wb_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iss_valid_i,
    input  logic          iss_writes_i,
    input  logic [AW-1:0] iss_rd_i,
    input  logic          commit_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic [AW-1:0] rs1_idx_i,
    input  logic [AW-1:0] rs2_idx_i,
    output logic          hazard_o,
    output logic [AW:0]   pend_cnt_o
);

    logic [NREG-1:0] pend_q, pend_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            set_en;
    logic            set_new;
    logic            clr_eff;
    logic            h1, h2;

    assign set_en = iss_valid_i && iss_writes_i && (iss_rd_i != '0);

    // Counter deltas are taken against the current bits so the count always
    // tracks popcount(pend): a re-set of a pending bit adds nothing, and a
    // clear overridden by a same-index set removes nothing.
    assign set_new = set_en && !pend_q[iss_rd_i];
    assign clr_eff = commit_i && pend_q[wb_rd_i] && !(set_en && (iss_rd_i == wb_rd_i));

    // NOTE: every signal assigned here gets its default first, so no path
    // through the block leaves a value held and no latch is inferred.
    always_comb begin
        pend_d = pend_q;
        if (commit_i) begin
            pend_d[wb_rd_i] = 1'b0;
        end
        // Applied after the clear so a same-index set wins: the newer
        // producer is still outstanding.
        if (set_en) begin
            pend_d[iss_rd_i] = 1'b1;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_eff};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Only registered pend bits count, so an instruction reading its own
    // destination in its issue cycle does not hazard on itself.
    assign h1 = (rs1_idx_i != '0) && pend_q[rs1_idx_i] &&
                !(commit_i && (wb_rd_i == rs1_idx_i));
    assign h2 = (rs2_idx_i != '0) && pend_q[rs2_idx_i] &&
                !(commit_i && (wb_rd_i == rs2_idx_i));

    assign hazard_o   = iss_valid_i && (h1 || h2);
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback-stage register file. Commits the final writeback mux result into a
// NREG x DW register array, serves two combinational read ports with
// write-to-read bypass, and reports pending-write hazards to the issue stage
// through the scoreboard sub-module. Register 0 always reads as zero.
//
// Ports
//   clock      in   clock, rising edge
//   reset      in   synchronous active-high reset
//   WB_VALID   in   retiring instruction present
//   WB_OPC     in   retiring opcode
//   WB_RD      in   retiring destination index
//   MUX_OUT    in   writeback data
//   ISS_VALID  in   instruction issues this cycle
//   ISS_OPC    in   issuing opcode
//   ISS_RD     in   issuing destination index
//   RS1_IDX    in   read port 1 / issuing source 1
//   RS2_IDX    in   read port 2 / issuing source 2
//   RD1, RD2   out  read data
//   HAZARD     out  issuing source pending and not bypassed
//   PEND_CNT   out  number of pending registers
// -----------------------------------------------------------------------------
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          WB_VALID,
    input  logic [5:0]    WB_OPC,
    input  logic [AW-1:0] WB_RD,
    input  logic [DW-1:0] MUX_OUT,
    input  logic          ISS_VALID,
    input  logic [5:0]    ISS_OPC,
    input  logic [AW-1:0] ISS_RD,
    input  logic [AW-1:0] RS1_IDX,
    input  logic [AW-1:0] RS2_IDX,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          HAZARD,
    output logic [AW:0]   PEND_CNT
);

    logic [DW-1:0] regs_q [NREG];
    logic          commit;

    assign commit = WB_VALID && opc_writes_rd(WB_OPC) && (WB_RD != '0);

    // NOTE: the register array is reset explicitly because a cleared file is
    // architecturally visible after reset; this forces flops rather than RAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[WB_RD] <= MUX_OUT;
        end
    end

    // Index 0 reads as zero with no bypass; otherwise a same-cycle commit to
    // the read index is forwarded ahead of the array.
    assign RD1 = (RS1_IDX == '0)                ? '0      :
                 (commit && (WB_RD == RS1_IDX)) ? MUX_OUT :
                                                  regs_q[RS1_IDX];
    assign RD2 = (RS2_IDX == '0)                ? '0      :
                 (commit && (WB_RD == RS2_IDX)) ? MUX_OUT :
                                                  regs_q[RS2_IDX];

    wb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .iss_valid_i  (ISS_VALID),
        .iss_writes_i (opc_writes_rd(ISS_OPC)),
        .iss_rd_i     (ISS_RD),
        .commit_i     (commit),
        .wb_rd_i      (WB_RD),
        .rs1_idx_i    (RS1_IDX),
        .rs2_idx_i    (RS2_IDX),
        .hazard_o     (HAZARD),
        .pend_cnt_o   (PEND_CNT)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Directed bench for wb_regfile: a table of per-cycle input/expected records
// walked in order (each row's expectations are the values seen before that
// row's clock edge), plus hand-written reset and fill/drain sequences.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    // Opcode numbers written out locally so a wrong package constant shows up.
    localparam logic [5:0] NOP = 6'd0,  ADD = 6'd1,  SUB = 6'd2,  STORE = 6'd3;
    localparam logic [5:0] LOAD = 6'd4, MOVE = 6'd5, NOT_ = 6'd15, MOVEI = 6'd16;
    localparam logic [5:0] ADDI = 6'd19, JUMP = 6'd21, BRA = 6'd22;
    localparam logic [5:0] ADDF = 6'd23, MULF = 6'd24, OP40 = 6'd40;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [5:0]  wb_opc;
    logic [4:0]  wb_rd;
    logic [31:0] mux_out;
    logic        iss_valid;
    logic [5:0]  iss_opc;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        hazard;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    wb_regfile dut (
        .clock     (clock),
        .reset     (reset),
        .WB_VALID  (wb_valid),
        .WB_OPC    (wb_opc),
        .WB_RD     (wb_rd),
        .MUX_OUT   (mux_out),
        .ISS_VALID (iss_valid),
        .ISS_OPC   (iss_opc),
        .ISS_RD    (iss_rd),
        .RS1_IDX   (rs1_idx),
        .RS2_IDX   (rs2_idx),
        .RD1       (rd1),
        .RD2       (rd2),
        .HAZARD    (hazard),
        .PEND_CNT  (pend_cnt)
    );

    typedef struct {
        logic        rst;
        logic        wv;
        logic [5:0]  wopc;
        logic [4:0]  wrd;
        logic [31:0] mux;
        logic        iv;
        logic [5:0]  iopc;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_haz;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, input logic wv, input logic [5:0] wopc, input logic [4:0] wrd,
        input logic [31:0] mux, input logic iv, input logic [5:0] iopc, input logic [4:0] ird,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] e_rd1,
        input logic [31:0] e_rd2, input logic e_haz, input logic [5:0] e_cnt);
        vec_t t;
        t.rst = rst;  t.wv = wv;   t.wopc = wopc; t.wrd = wrd;   t.mux = mux;
        t.iv = iv;    t.iopc = iopc; t.ird = ird; t.rs1 = rs1;   t.rs2 = rs2;
        t.e_rd1 = e_rd1; t.e_rd2 = e_rd2; t.e_haz = e_haz; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wv, input logic [5:0] wopc,
                         input logic [4:0] wrd, input logic [31:0] mux, input logic iv,
                         input logic [5:0] iopc, input logic [4:0] ird,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        reset = rst;  wb_valid = wv;  wb_opc = wopc; wb_rd = wrd; mux_out = mux;
        iss_valid = iv; iss_opc = iopc; iss_rd = ird; rs1_idx = rs1; rs2_idx = rs2;
    endtask

    initial begin
        // Reset for two edges, then sweep every index on both ports.
        drive(1'b1, 1'b0, NOP, 5'd0, 32'h0, 1'b0, NOP, 5'd0, 5'd0, 5'd0);
        @(posedge clock);
        @(posedge clock);
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            drive(1'b0, 1'b0, NOP, 5'd0, 32'h0, 1'b0, NOP, 5'd0, 5'(i), 5'(32 - i));
            #1;
            check($sformatf("reset rd1 idx%0d", i), rd1, 32'h0);
            check($sformatf("reset rd2 idx%0d", 32 - i), rd2, 32'h0);
            check($sformatf("reset cnt idx%0d", i), 32'(pend_cnt), 32'h0);
        end

        //                rst wv wopc   wrd  mux           iv iopc  ird  rs1  rs2   e_rd1         e_rd2         haz cnt
        vecs.push_back(v(0, 1, ADD,   5,  32'hDEADBEEF, 0, NOP,  0,   5,   0,   32'hDEADBEEF, 32'h0,        0,  0)); // 0 bypass
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   5,   5,   32'hDEADBEEF, 32'hDEADBEEF, 0,  0)); // 1 from regs
        vecs.push_back(v(0, 1, STORE, 5,  32'h1,        0, NOP,  0,   5,   0,   32'hDEADBEEF, 32'h0,        0,  0)); // 2 store no write
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   5,   0,   32'hDEADBEEF, 32'h0,        0,  0)); // 3
        vecs.push_back(v(0, 1, MOVEI, 0,  32'h1234,     0, NOP,  0,   0,   5,   32'h0,        32'hDEADBEEF, 0,  0)); // 4 write r0
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   0,   0,   32'h0,        32'h0,        0,  0)); // 5
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, ADDI, 7,   7,   0,   32'h0,        32'h0,        0,  0)); // 6 own src no hazard
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, ADD,  0,   0,   7,   32'h0,        32'h0,        1,  1)); // 7 hazard
        vecs.push_back(v(0, 1, ADDI,  7,  32'h777,      1, ADD,  0,   0,   7,   32'h0,        32'h777,      0,  1)); // 8 bypass kills hazard
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   0,   7,   32'h0,        32'h777,      0,  0)); // 9
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, ADD,  9,   9,   0,   32'h0,        32'h0,        0,  0)); // 10 set r9
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   9,   0,   32'h0,        32'h0,        0,  1)); // 11 iss_valid low
        vecs.push_back(v(0, 1, SUB,   9,  32'h99,       1, ADD,  9,   0,   9,   32'h0,        32'h99,       0,  1)); // 12 set+clr same idx
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, NOP,  0,   9,   0,   32'h99,       32'h0,        1,  1)); // 13 r9 still pending
        vecs.push_back(v(0, 1, ADD,   9,  32'hAA,       1, ADD,  3,   0,   0,   32'h0,        32'h0,        0,  1)); // 14 set r3 clr r9
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, NOP,  0,   3,   9,   32'h0,        32'hAA,       1,  1)); // 15 net zero
        vecs.push_back(v(0, 1, MOVE,  12, 32'hC,        0, NOP,  0,   12,  0,   32'hC,        32'h0,        0,  1)); // 16 commit unpended
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   12,  0,   32'hC,        32'h0,        0,  1)); // 17 cnt unchanged
        vecs.push_back(v(0, 1, ADD,   3,  32'h33,       0, NOP,  0,   3,   0,   32'h33,       32'h0,        0,  1)); // 18 clr r3
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, LOAD, 10,  0,   0,   32'h0,        32'h0,        0,  0)); // 19 set r10
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, LOAD, 11,  0,   0,   32'h0,        32'h0,        0,  1)); // 20 set r11
        vecs.push_back(v(1, 1, ADD,   12, 32'hFFFF,     1, LOAD, 13,  0,   0,   32'h0,        32'h0,        0,  2)); // 21 reset edge
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, NOP,  0,   10,  11,  32'h0,        32'h0,        0,  0)); // 22 pend discarded
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   12,  5,   32'h0,        32'h0,        0,  0)); // 23 no write on reset
        vecs.push_back(v(0, 1, JUMP,  12, 32'h5,        0, NOP,  0,   12,  0,   32'h0,        32'h0,        0,  0)); // 24 jump no write
        vecs.push_back(v(0, 1, OP40,  12, 32'h6,        0, NOP,  0,   12,  0,   32'h0,        32'h0,        0,  0)); // 25 undefined opc
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, BRA,  13,  0,   12,  32'h0,        32'h0,        0,  0)); // 26 bra no set
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, NOP,  0,   13,  0,   32'h0,        32'h0,        0,  0)); // 27
        vecs.push_back(v(0, 1, MULF,  12, 32'h24,       0, NOP,  0,   12,  0,   32'h24,       32'h0,        0,  0)); // 28 mulf writes
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, NOT_, 14,  0,   12,  32'h0,        32'h24,       0,  0)); // 29 not sets
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        1, NOP,  0,   14,  0,   32'h0,        32'h0,        1,  1)); // 30
        vecs.push_back(v(0, 1, ADDF,  14, 32'h23,       0, NOP,  0,   14,  0,   32'h23,       32'h0,        0,  1)); // 31 addf writes
        vecs.push_back(v(0, 0, NOP,   0,  32'h0,        0, NOP,  0,   14,  0,   32'h23,       32'h0,        0,  0)); // 32

        foreach (vecs[n]) begin
            @(negedge clock);
            drive(vecs[n].rst, vecs[n].wv, vecs[n].wopc, vecs[n].wrd, vecs[n].mux,
                  vecs[n].iv, vecs[n].iopc, vecs[n].ird, vecs[n].rs1, vecs[n].rs2);
            #1;
            check($sformatf("v%0d rd1", n), rd1, vecs[n].e_rd1);
            check($sformatf("v%0d rd2", n), rd2, vecs[n].e_rd2);
            check($sformatf("v%0d hazard", n), 32'(hazard), 32'(vecs[n].e_haz));
            check($sformatf("v%0d pend_cnt", n), 32'(pend_cnt), 32'(vecs[n].e_cnt));
        end

        // Fill: issue a writer to every register 1..31; count climbs to 31.
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            drive(1'b0, 1'b0, NOP, 5'd0, 32'h0, 1'b1, ADD, 5'(i), 5'd0, 5'd0);
            #1;
            check($sformatf("fill cnt %0d", i), 32'(pend_cnt), 32'(i - 1));
        end
        @(negedge clock);
        drive(1'b0, 1'b0, NOP, 5'd0, 32'h0, 1'b1, NOP, 5'd0, 5'd31, 5'd0);
        #1;
        check("full cnt", 32'(pend_cnt), 32'd31);
        check("full hazard", 32'(hazard), 32'd1);

        // Drain: commit each register; count falls back to 0 and data lands.
        for (int i = 1; i < 32; i++) begin
            @(negedge clock);
            drive(1'b0, 1'b1, ADD, 5'(i), 32'(i) * 32'h101, 1'b0, NOP, 5'd0, 5'(i), 5'd0);
            #1;
            check($sformatf("drain cnt %0d", i), 32'(pend_cnt), 32'(32 - i));
        end
        @(negedge clock);
        drive(1'b0, 1'b0, NOP, 5'd0, 32'h0, 1'b1, NOP, 5'd0, 5'd31, 5'd17);
        #1;
        check("drained cnt", 32'(pend_cnt), 32'd0);
        check("drained hazard", 32'(hazard), 32'd0);
        check("drained r31", rd1, 32'd31 * 32'h101);
        check("drained r17", rd2, 32'd17 * 32'h101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
